// File: rtl/prio_grant_pkg.sv
// Shared constants and FSM state type for prio_grant_queue.
// Optional one-hot output of the top is enabled by PRIO_GRANT_ONEHOT_EN.
package prio_grant_pkg;

  localparam int unsigned MODE_FIXED = 0;
  localparam int unsigned MODE_RR    = 1;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

endpackage

// File: rtl/prio_find.sv
// Combinational search for the first set bit of mask scanning downward from
// start (inclusive, wrapping), or from the top index when rotate is low.
module prio_find #(
  parameter  int unsigned WIDTH = 8,
  localparam int unsigned IW    = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] mask,
  input  logic [IW-1:0]    start,
  input  logic             rotate,
  output logic [IW-1:0]    index,
  output logic             found
);

  int unsigned base;
  int unsigned pos;

  always_comb begin
    index = '0;
    found = 1'b0;
    base  = rotate ? 32'(start) : WIDTH - 1;
    pos   = 0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      pos = (base + WIDTH - i) % WIDTH;
      if (!found && mask[IW'(pos)]) begin
        found = 1'b1;
        index = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/prio_grant_queue.sv
// Pending-request queue granting one index per handshake, fixed or round-robin.
// Define PRIO_GRANT_ONEHOT_EN to add the out_onehot decode output.
module prio_grant_queue
  import prio_grant_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned MODE  = MODE_FIXED
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         req_in,
  input  logic                     load,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [$clog2(WIDTH)-1:0] out_idx,
  output logic                     busy
`ifdef PRIO_GRANT_ONEHOT_EN
  ,
  output logic [WIDTH-1:0]         out_onehot
`endif
);

  localparam int unsigned IW = $clog2(WIDTH);

  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] pending_next;
  logic [WIDTH-1:0] grant_onehot;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    ptr_next;
  logic [IW-1:0]    find_idx;
  logic             find_ok;
  logic             grant;
  state_t           state;
  state_t           state_next;

  // Outputs depend only on registered pending/ptr, never on req_in or load.
  prio_find #(.WIDTH(WIDTH)) u_find (
    .mask   (pending),
    .start  (ptr),
    .rotate (MODE == MODE_RR),
    .index  (find_idx),
    .found  (find_ok)
  );

  assign out_valid = |pending;
  assign out_idx   = out_valid ? find_idx : '0;
  assign busy      = (state == ST_ACTIVE);
  assign grant     = out_valid && out_ready;

  always_comb begin
    grant_onehot = '0;
    if (grant) grant_onehot = WIDTH'(1) << out_idx;
    pending_next = (pending & ~grant_onehot) | (load ? req_in : '0);
    ptr_next     = ptr;
    if (MODE == MODE_RR && grant)
      ptr_next = (out_idx == '0) ? IW'(WIDTH - 1) : out_idx - 1'b1;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (pending_next != '0) state_next = ST_ACTIVE;
      ST_ACTIVE: if (pending_next == '0) state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      ptr     <= IW'(WIDTH - 1);
      state   <= ST_IDLE;
    end else begin
      pending <= pending_next;
      ptr     <= ptr_next;
      state   <= state_next;
    end
  end

`ifdef PRIO_GRANT_ONEHOT_EN
  assign out_onehot = out_valid ? (WIDTH'(1) << out_idx) : '0;
`endif

endmodule

// File: tb/tb_prio_grant_queue.sv
// Directed bench for prio_grant_queue: one fixed-priority and one round-robin
// instance (WIDTH=8); PRIO_GRANT_ONEHOT_EN adds the one-hot output checks.
module tb_prio_grant_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] f_req, r_req;
  logic       f_load, r_load, f_ready, r_ready;
  logic       f_valid, r_valid, f_busy, r_busy;
  logic [2:0] f_idx, r_idx;
`ifdef PRIO_GRANT_ONEHOT_EN
  logic [7:0] f_oh, r_oh;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  prio_grant_queue #(.WIDTH(8), .MODE(0)) u_fixed (
    .clk(clk), .rst(rst), .req_in(f_req), .load(f_load), .out_ready(f_ready),
    .out_valid(f_valid), .out_idx(f_idx), .busy(f_busy)
`ifdef PRIO_GRANT_ONEHOT_EN
    , .out_onehot(f_oh)
`endif
  );

  prio_grant_queue #(.WIDTH(8), .MODE(1)) u_rr (
    .clk(clk), .rst(rst), .req_in(r_req), .load(r_load), .out_ready(r_ready),
    .out_valid(r_valid), .out_idx(r_idx), .busy(r_busy)
`ifdef PRIO_GRANT_ONEHOT_EN
    , .out_onehot(r_oh)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    f_req = '0; f_load = 1'b0; f_ready = 1'b0;
    r_req = '0; r_load = 1'b0; r_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_f_valid", f_valid, 0);
    chk("rst_f_idx",   f_idx,   0);
    chk("rst_f_busy",  f_busy,  0);
    chk("rst_r_valid", r_valid, 0);
    chk("rst_r_idx",   r_idx,   0);
    chk("rst_r_busy",  r_busy,  0);

    // Fixed priority drain of A4
    f_req = 8'hA4; f_load = 1'b1; f_ready = 1'b1;
    step();
    f_load = 1'b0;
    chk("fix_valid1", f_valid, 1);
    chk("fix_busy1",  f_busy,  1);
    chk("fix_idx7",   f_idx,   7);
    step();
    chk("fix_idx5",   f_idx,   5);
    step();
    chk("fix_idx2",   f_idx,   2);
    step();
    chk("fix_valid0", f_valid, 0);
    chk("fix_busy0",  f_busy,  0);
    chk("fix_idx0",   f_idx,   0);

    // Fixed priority hold: a later higher load overtakes
    f_ready = 1'b0; f_req = 8'h04; f_load = 1'b1;
    step();
    chk("fix_hold_idx2", f_idx, 2);
    f_req = 8'h10;
    step();
    f_load = 1'b0;
    chk("fix_hold_idx4", f_idx, 4);
    f_ready = 1'b1;
    step();
    chk("fix_after_idx2", f_idx, 2);
    step();
    f_ready = 1'b0;
    chk("fix_empty", f_valid, 0);

    // Round-robin hold with pending 12, ptr=7
    r_req = 8'h12; r_load = 1'b1; r_ready = 1'b0;
    step();
    r_load = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("rr_hold_idx4", r_idx, 4);
      chk("rr_hold_valid", r_valid, 1);
      step();
    end
    chk("rr_hold_idx4_end", r_idx, 4);
    r_ready = 1'b1;
    step();
    chk("rr_drain_idx1", r_idx, 1);
    step();
    chk("rr_drain_empty", r_valid, 0);

    // ptr=0: load 20 -> idx 5 via wrap; grant leaves ptr=4
    r_ready = 1'b0; r_req = 8'h20; r_load = 1'b1;
    step();
    r_load = 1'b0;
    chk("rr_wrap_idx5", r_idx, 5);
`ifdef PRIO_GRANT_ONEHOT_EN
    chk("oh_idx5", r_oh, 8'h20);
`endif
    r_ready = 1'b1;
    step();
    chk("rr_g5_empty", r_valid, 0);
`ifdef PRIO_GRANT_ONEHOT_EN
    chk("oh_empty", r_oh, 8'h00);
`endif

    // ptr=4: load A1 -> 0, 7, 5
    r_ready = 1'b0; r_req = 8'hA1; r_load = 1'b1;
    step();
    r_load = 1'b0;
    chk("rr_seq_idx0", r_idx, 0);
    r_ready = 1'b1;
    step();
    chk("rr_seq_idx7", r_idx, 7);
    step();
    chk("rr_seq_idx5", r_idx, 5);
    step();
    chk("rr_seq_empty", r_valid, 0);
    chk("rr_seq_busy0", r_busy, 0);

    // Grant and reload the same bit in one cycle
    r_ready = 1'b0; r_req = 8'h04; r_load = 1'b1;
    step();
    chk("rr_reload_idx2a", r_idx, 2);
    r_ready = 1'b1;
    step();
    r_load = 1'b0;
    chk("rr_reload_valid", r_valid, 1);
    chk("rr_reload_idx2b", r_idx, 2);
    step();
    chk("rr_reload_empty", r_valid, 0);

    // ptr=1: drain FF for two grants, then reset mid-drain
    r_ready = 1'b0; r_req = 8'hFF; r_load = 1'b1;
    step();
    r_load = 1'b0;
    chk("rr_ff_idx1", r_idx, 1);
    r_ready = 1'b1;
    step();
    chk("rr_ff_idx0", r_idx, 0);
    step();
    chk("rr_ff_idx7", r_idx, 7);
    rst = 1'b1; r_load = 1'b1;
    step();
    rst = 1'b0; r_load = 1'b0;
    chk("rr_rst_valid", r_valid, 0);
    chk("rr_rst_busy",  r_busy,  0);
    chk("rr_rst_idx",   r_idx,   0);
    step();
    chk("rr_rst_stays", r_valid, 0);

    // After reset ptr=7: load 01 wraps to grant 0
    r_ready = 1'b0; r_req = 8'h01; r_load = 1'b1;
    step();
    r_load = 1'b0;
    chk("rr_post_valid", r_valid, 1);
    chk("rr_post_idx0",  r_idx,   0);
    chk("rr_post_busy",  r_busy,  1);
    r_ready = 1'b1;
    step();
    chk("rr_post_empty", r_valid, 0);
    chk("rr_post_idle",  r_busy,  0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
